// File: rtl/dff_bank_arbiter_if.sv
// Bus between the lab front-end requesters and the register-bank arbiter.
interface dff_bank_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_a;
  logic [WIDTH-1:0] wdata_a;
  logic             req_b;
  logic [WIDTH-1:0] wdata_b;
  logic             clr_req;
  logic             gnt_a;
  logic             gnt_b;
  logic             clr_ack;
  logic             busy;
  logic             last_owner;
  logic [WIDTH-1:0] q;

  // Requester side: raises requests and watches grants and bank contents.
  modport master (
    output req_a, wdata_a, req_b, wdata_b, clr_req,
    input  gnt_a, gnt_b, clr_ack, busy, last_owner, q
  );

  // Arbiter side.
  modport slave (
    input  req_a, wdata_a, req_b, wdata_b, clr_req,
    output gnt_a, gnt_b, clr_ack, busy, last_owner, q
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter/sequencer for a bank of dff cells. Writes from A and B
// and bank clears are serialised into one-cycle operations, each followed by
// at least one IDLE cycle.

// Storage cell: enable flop with asynchronous active-high clear. The clear
// input is only ever driven from a register, so it is glitch-free.
module dff (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);
  // Capture d when enabled; clear overrides everything.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) q <= 1'b0;
    else if (en) q <= d;
  end
endmodule

module dff_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              clr,
  dff_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    CLR  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             last_owner_reg, last_owner_next;
  logic [WIDTH-1:0] wr_data_reg, wr_data_next;
  logic             gnt_a_reg, gnt_a_next;
  logic             gnt_b_reg, gnt_b_next;
  logic             clr_ack_reg, clr_ack_next;
  logic             cell_clr_reg;
  logic             cell_en;
  logic             pick_b;
  logic [WIDTH-1:0] q_bits;

  // Next-state decision: clear beats writes; a tie goes to whoever did not
  // win the previous write.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    wr_data_next    = wr_data_reg;
    gnt_a_next      = 1'b0;
    gnt_b_next      = 1'b0;
    clr_ack_next    = 1'b0;
    pick_b          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.clr_req) begin
          state_next   = CLR;
          clr_ack_next = 1'b1;
        end else if (bus.req_a || bus.req_b) begin
          if (bus.req_a && bus.req_b) pick_b = ~last_owner_reg;
          else                        pick_b = bus.req_b;
          state_next   = WR;
          owner_next   = pick_b;
          wr_data_next = pick_b ? bus.wdata_b : bus.wdata_a;
          gnt_a_next   = ~pick_b;
          gnt_b_next   = pick_b;
        end
      end
      WR: begin
        state_next      = IDLE;
        last_owner_next = owner_reg;
      end
      CLR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM, grant pulses and write-data holding register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b1;
      last_owner_reg <= 1'b1;
      wr_data_reg    <= '0;
      gnt_a_reg      <= 1'b0;
      gnt_b_reg      <= 1'b0;
      clr_ack_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      wr_data_reg    <= wr_data_next;
      gnt_a_reg      <= gnt_a_next;
      gnt_b_reg      <= gnt_b_next;
      clr_ack_reg    <= clr_ack_next;
    end
  end

  // Registered cell clear: pulses the cycle after reset or after a CLR cycle.
  always_ff @(posedge clk) begin
    cell_clr_reg <= clr | (state_reg == CLR);
  end

  assign cell_en = (state_reg == WR);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      dff u_cell (
        .clk (clk),
        .clr (cell_clr_reg),
        .en  (cell_en),
        .d   (wr_data_reg[gi]),
        .q   (q_bits[gi])
      );
    end
  endgenerate

  assign bus.gnt_a      = gnt_a_reg;
  assign bus.gnt_b      = gnt_b_reg;
  assign bus.clr_ack    = clr_ack_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.last_owner = last_owner_reg;
  assign bus.q          = q_bits;

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Two-requester round-robin arbiter and sequencer for a WIDTH-bit register bank built from `dff` cells (clk, async active-high clr, en, d, q). The block instantiates the WIDTH cells internally and is the only driver of their en/d/clr lines. It serialises writes from requesters A and B and bank-clear requests into single-cycle bank operations. It sits between lab front-end logic (switch/button debouncers) and the LED/display register it drives.

## Interface
- WIDTH, 8, bank width in bits (1..32)
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- req_a  in  1  write request, requester A; level, held until gnt_a
- wdata_a  in  WIDTH  write data, A; sampled on the granting edge
- req_b  in  1  write request, requester B
- wdata_b  in  WIDTH  write data, B
- clr_req  in  1  bank-clear request; level, held until clr_ack
- gnt_a  out  1  one-cycle pulse: A's write accepted
- gnt_b  out  1  one-cycle pulse: B's write accepted
- clr_ack  out  1  one-cycle pulse: clear accepted
- busy  out  1  high while an operation is executing (state ≠ IDLE)
- last_owner  out  1  0 = A won the last write, 1 = B
- q  out  WIDTH  bank contents (cell q outputs)

## Operation
- FSM states: IDLE, WR, CLR. All FSM, grant, data and cell-clear registers are clocked by clk and reset synchronously by clr.
- IDLE, decision priority at the edge:
  - clr_req=1 → CLR, clr_ack←1.
  - Else exactly one of req_a/req_b → WR, owner←that requester, wr_data←its wdata, that gnt←1.
  - Else both requests → owner←!last_owner (round robin), with the same side effects.
  - Else stay in IDLE.
- WR (one cycle): cell en=1, cell d=wr_data. last_owner←owner at the exit edge. Next state is IDLE unconditionally.
- CLR (one cycle): cell en=0. The registered cell-clear line is 1 during the following cycle. Next state is IDLE.
- Cell en = (state==WR) and is 0 in all other states. Cell d = wr_data. Cell clr = registered (clr | state==CLR).
- The bank holds its value indefinitely in IDLE.
- Requesters must drop req in the cycle after their gnt. A req still held in the IDLE cycle that follows is treated as a new request.
- last_owner changes only on writes. Clears do not change it.

## Timing
- Reset values, effective the cycle after the reset edge:
  - state=IDLE, gnt_a=gnt_b=clr_ack=0, busy=0
  - last_owner=1, so A wins the first tie
  - wr_data=0
  - q=0, via the cell-clear line being high that cycle
- Write latency: req sampled high in IDLE at cycle T.
  - gnt pulse and busy=1 in T+1 (WR).
  - New q visible from T+2.
  - Back in IDLE in T+2.
- Clear latency: clr_req high in IDLE at T.
  - clr_ack and busy in T+1 (CLR).
  - Cell clr high in T+2, so q=0 from T+2.
  - IDLE at T+2.
- Throughput: at most one operation per 2 cycles. Requests arriving while busy are not sampled until the next IDLE cycle.
- Simultaneous clr_req and write request: the clear wins and the write request waits. Each grant is a single pulse, never two in one cycle.
- Reset during WR: the cell may capture wr_data at that edge, but the cell clear forces q=0 from the next cycle. last_owner=1, and no further gnt is issued.
- Reset during CLR or IDLE: same end state as reset from any state.
- WIDTH arithmetic: data paths are straight WIDTH-bit copies with no extension or truncation.

## Test plan
- Reset: hold clr for 2 cycles with req_a=1, wdata_a=8'hFF.
  - During reset and the cycle after: q=8'h00, no gnt.
  - First post-reset IDLE: gnt_a in the following cycle, q=8'hFF two cycles after sampling.
- Single writes: A writes 8'h5A, then B writes 8'hC3.
  - Each gnt is exactly one cycle.
  - q=8'h5A, then q=8'hC3, each at T+2.
  - last_owner goes 0 then 1.
- Round robin: hold req_a and req_b high continuously from reset with wdata_a=8'h11, wdata_b=8'h22.
  - Grants alternate A,B,A,B on every second cycle.
  - q alternates 8'h11/8'h22.
- Clear priority: q=8'h5A; assert clr_req, req_a (8'h77) and req_b together.
  - clr_ack first, q=8'h00 at T+2.
  - Then gnt_a, because last_owner is unchanged by the clear.
  - q=8'h77 two cycles after gnt_a's sampling edge.
- Reset mid-write: assert clr in the WR cycle of an A write of 8'hAA over q=8'h33.
  - q=8'h00 the cycle after the reset edge.
  - busy=0, last_owner=1, no second gnt_a.
- Busy blocking: assert req_b during the WR cycle of an A write.
  - gnt_b is not issued in that cycle.
  - gnt_b is issued one cycle after the following IDLE cycle.
